// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state enum and control-word type for the multicycle MIPS controller.
// Optional macro MIPS_ADDI_EN adds the addi opcode and its two states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRcomp  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic op_legal(logic [5:0] op);
    logic legal;
    legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
            (op == OP_J);
`ifdef MIPS_ADDI_EN
    legal = legal || (op == OP_ADDI);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle; master is the control FSM side.
interface mips_multicycle_control_if #(
  parameter int unsigned STATE_W = 4
);
  logic [5:0]         Op;
  logic               Zero;
  logic               MemReady;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic               InstrDone;
  logic               Illegal;
  logic [STATE_W-1:0] State;

  modport master (
    input  Op, Zero, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Illegal, State
  );

  modport slave (
    output Op, Zero, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Illegal, State
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Pure combinational state-to-control-word decoder (Moore outputs plus MemReady gating).
// Optional macro MIPS_ADDI_EN enables the addi states.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.illegal   = ~op_legal(op_i);
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      StExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      StRcomp: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
`ifdef MIPS_ADDI_EN
      StAddiEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StAddiWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: next-state logic and state register around the decoder.
// Optional macro MIPS_ADDI_EN adds addi (ADDI_EX/ADDI_WB).
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mips_multicycle_control_if.master   bus
);

  state_e     state_q, state_d;
  logic       started_q;
  logic       ready_eff;
  ctrl_word_t cw, cw_out;

  // First edge after reset release must stay in FETCH, so MemReady is ignored until then.
  assign ready_eff = bus.MemReady & started_q;

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = ready_eff ? StDecode : StFetch;
      StDecode: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExec;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
`ifdef MIPS_ADDI_EN
          OP_ADDI:      state_d = StAddiEx;
`endif
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (bus.Op == OP_LW) ? StMemRd : StMemWr;
      StMemRd:  state_d = ready_eff ? StMemWb : StMemRd;
      StMemWr:  state_d = ready_eff ? StFetch : StMemWr;
      StExec:   state_d = StRcomp;
`ifdef MIPS_ADDI_EN
      StAddiEx: state_d = StAddiWb;
`endif
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .op_i        (bus.Op),
    .mem_ready_i (ready_eff),
    .ctrl_o      (cw)
  );

  // Reset forces every output low even though the register already sits in FETCH.
  assign cw_out          = rst_n ? cw : '0;
  assign bus.PCWrite     = cw_out.pc_write;
  assign bus.PCWriteCond = cw_out.pc_write_cond;
  assign bus.IorD        = cw_out.iord;
  assign bus.MemRead     = cw_out.mem_read;
  assign bus.MemWrite    = cw_out.mem_write;
  assign bus.IRWrite     = cw_out.ir_write;
  assign bus.MemtoReg    = cw_out.mem_to_reg;
  assign bus.RegDst      = cw_out.reg_dst;
  assign bus.RegWrite    = cw_out.reg_write;
  assign bus.ALUSrcA     = cw_out.alu_src_a;
  assign bus.ALUSrcB     = cw_out.alu_src_b;
  assign bus.ALUOp       = cw_out.alu_op;
  assign bus.PCSource    = cw_out.pc_source;
  assign bus.InstrDone   = cw_out.instr_done;
  assign bus.Illegal     = cw_out.illegal;
  assign bus.State       = rst_n ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Trace-driven bench: each instruction expands into its expected per-cycle state sequence,
// and every cycle's outputs are compared against the per-state output table.
module tb_mips_multicycle_control;

  typedef struct {
    int         st;
    bit         mr;
    bit         eff;
    bit         rst;
    logic [5:0] op;
    bit         zero;
  } cyc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mips_multicycle_control_if #(.STATE_W(4)) bus ();

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  cyc_t trace[$];
  int   n_vec    = 0;
  int   n_bad    = 0;
  int   done_cnt = 0;
  int   ill_cnt  = 0;
  int   mw_run   = 0;
  int   mw_max   = 0;

  function automatic bit legal(logic [5:0] op);
    bit l;
    l = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
        (op == 6'b000100) || (op == 6'b000010);
`ifdef MIPS_ADDI_EN
    l = l || (op == 6'b001000);
`endif
    return l;
  endfunction

  // Expected {controls, State} for one cycle, straight from the per-state output table.
  function automatic logic [21:0] expect_vec(cyc_t c);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, done, ill;
    logic [1:0] sb, aop, pcs;
    logic [3:0] st;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, done, ill} = '0;
    sb  = 2'b00;
    aop = 2'b00;
    pcs = 2'b00;
    st  = c.rst ? 4'd0 : 4'(c.st);
    if (!c.rst) begin
      case (c.st)
        0:  begin mrd = 1'b1; sb = 2'b01; irw = c.eff; pcw = c.eff; end
        1:  begin sb = 2'b11; ill = !legal(c.op); end
        2:  begin sa = 1'b1; sb = 2'b10; end
        3:  begin mrd = 1'b1; iord = 1'b1; end
        4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
        5:  begin mwr = 1'b1; iord = 1'b1; done = c.eff; end
        6:  begin sa = 1'b1; aop = 2'b10; end
        7:  begin rw = 1'b1; rdst = 1'b1; done = 1'b1; end
        8:  begin sa = 1'b1; aop = 2'b01; pcc = 1'b1; pcs = 2'b01; done = 1'b1; end
        9:  begin pcw = 1'b1; pcs = 2'b10; done = 1'b1; end
        10: begin sa = 1'b1; sb = 2'b10; end
        11: begin rw = 1'b1; done = 1'b1; end
        default: ;
      endcase
    end
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, pcs, done, ill, st};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.PCSource, bus.InstrDone, bus.Illegal, bus.State};
  endfunction

  task automatic add(int st, bit mr, bit eff, logic [5:0] op, bit zero, bit rst);
    cyc_t c;
    c.st = st; c.mr = mr; c.eff = eff; c.rst = rst; c.op = op; c.zero = zero;
    trace.push_back(c);
  endtask

  // Expected cycle trace of one instruction, with fst fetch stalls and mst memory stalls.
  task automatic add_instr(logic [5:0] op, bit zero, int fst, int mst);
    for (int i = 0; i < fst; i++) add(0, 1'b0, 1'b0, op, zero, 1'b0);
    add(0, 1'b1, 1'b1, op, zero, 1'b0);
    add(1, 1'b1, 1'b1, op, zero, 1'b0);
    if (op == 6'b100011) begin
      add(2, 1'b1, 1'b1, op, zero, 1'b0);
      for (int i = 0; i < mst; i++) add(3, 1'b0, 1'b0, op, zero, 1'b0);
      add(3, 1'b1, 1'b1, op, zero, 1'b0);
      add(4, 1'b1, 1'b1, op, zero, 1'b0);
    end else if (op == 6'b101011) begin
      add(2, 1'b1, 1'b1, op, zero, 1'b0);
      for (int i = 0; i < mst; i++) add(5, 1'b0, 1'b0, op, zero, 1'b0);
      add(5, 1'b1, 1'b1, op, zero, 1'b0);
    end else if (op == 6'b000000) begin
      add(6, 1'b1, 1'b1, op, zero, 1'b0);
      add(7, 1'b1, 1'b1, op, zero, 1'b0);
    end else if (op == 6'b000100) begin
      add(8, 1'b1, 1'b1, op, zero, 1'b0);
    end else if (op == 6'b000010) begin
      add(9, 1'b1, 1'b1, op, zero, 1'b0);
    end else if (legal(op)) begin
      add(10, 1'b1, 1'b1, op, zero, 1'b0);
      add(11, 1'b1, 1'b1, op, zero, 1'b0);
    end
  endtask

  task automatic lit(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_cycle(cyc_t c);
    logic [21:0] exp, act;
    exp = expect_vec(c);
    act = dut_vec();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cycle t=%0t st=%0d op=%b: got %b, expected %b", $time, c.st, c.op, act,
               exp);
    end
    done_cnt += int'(bus.InstrDone);
    ill_cnt  += int'(bus.Illegal);
    mw_run = bus.MemWrite ? mw_run + 1 : 0;
    if (mw_run > mw_max) mw_max = mw_run;
  endtask

  task automatic play();
    cyc_t c;
    while (trace.size() > 0) begin
      c = trace.pop_front();
      @(posedge clk);
      #1;
      rst_n        = !c.rst;
      bus.MemReady = c.mr;
      bus.Op       = c.op;
      bus.Zero     = c.zero;
      @(negedge clk);
      check_cycle(c);
    end
  endtask

  int d_done, d_ill;

  initial begin
    bus.Op = 6'b0; bus.Zero = 1'b0; bus.MemReady = 1'b1;

    // Power-on reset, then release with MemReady high: one held FETCH cycle first.
    add(0, 1'b1, 1'b0, 6'b0, 1'b0, 1'b1);
    add(0, 1'b1, 1'b0, 6'b0, 1'b0, 1'b1);
    play();
    lit("reset_state", int'(bus.State), 0);
    lit("reset_memread", int'(bus.MemRead), 0);
    add(0, 1'b1, 1'b0, 6'b100011, 1'b0, 1'b0);
    play();

    d_done = done_cnt;
    add_instr(6'b100011, 1'b0, 0, 0);
    play();
    lit("lw_instrdone_pulses", done_cnt - d_done, 1);

    d_done = done_cnt; mw_max = 0;
    add_instr(6'b101011, 1'b0, 1, 3);
    play();
    lit("sw_memwrite_run", mw_max, 4);
    lit("sw_instrdone_pulses", done_cnt - d_done, 1);

    d_done = done_cnt;
    add_instr(6'b000100, 1'b1, 0, 0);
    add_instr(6'b000100, 1'b0, 0, 0);
    play();
    lit("beq_instrdone_pulses", done_cnt - d_done, 2);

    add_instr(6'b000000, 1'b0, 0, 0);
    add_instr(6'b000010, 1'b0, 0, 0);
    play();

    d_done = done_cnt; d_ill = ill_cnt;
    add_instr(6'b001000, 1'b0, 0, 0);
    play();
`ifdef MIPS_ADDI_EN
    lit("addi_illegal_pulses", ill_cnt - d_ill, 0);
    lit("addi_instrdone_pulses", done_cnt - d_done, 1);
`else
    lit("addi_illegal_pulses", ill_cnt - d_ill, 1);
    lit("addi_instrdone_pulses", done_cnt - d_done, 0);
`endif

    d_ill = ill_cnt;
    add_instr(6'b111111, 1'b0, 0, 0);
    play();
    lit("bad_op_illegal_pulses", ill_cnt - d_ill, 1);

    add_instr(6'b100011, 1'b0, 2, 1);
    play();

    // Abort in the middle of EXEC: outputs must drop without waiting for an edge.
    add(0, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0);
    add(1, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0);
    add(6, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0);
    play();
    #2 rst_n = 1'b0;
    #1;
    lit("abort_outputs", int'(dut_vec()), 0);
    add(0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1);
    add(0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0);
    add_instr(6'b000000, 1'b0, 0, 0);
    play();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register and sequences fetch, decode, execute, memory and writeback. Each cycle it drives the datapath enables, the mux selects, and the 2-bit ALUOp that feeds the ALU control decoder. It stalls on memory through a ready handshake and flags unsupported opcodes.

Parameters:
- STATE_W, 4, width of the state register and of the State debug port.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Op  in  6  opcode field IR[31:26], valid from DECODE onward
- Zero  in  1  ALU zero flag, sampled in BRANCH
- MemReady  in  1  memory completes the access in this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load when Zero=1
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data select: 0=ALUOut, 1=MDR
- RegDst  out  1  destination register select: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A
- ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2
- ALUOp  out  2  00=add, 01=sub, 10=funct decode
- PCSource  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- InstrDone  out  1  one-cycle pulse when an instruction retires
- Illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- State  out  STATE_W  current state, for debug

Behaviour:
- Moore FSM. All outputs decode from the state register only, except the MemReady gating listed below.
- While rst_n=0: state=FETCH, and every output is forced to 0 (State=0).
- State encoding and transitions:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite = MemReady. Go to DECODE when MemReady=1, else stay.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Next state by Op:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXEC
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - any other opcode → FETCH with Illegal=1 and no architectural writes
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEMRD, sw → MEMWR.
  - MEMRD(3): MemRead=1, IorD=1. Wait for MemReady, then → MEMWB.
  - MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1 → FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. Wait for MemReady, then InstrDone=1 → FETCH.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 → RCOMP.
  - RCOMP(7): RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1 → FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1 → FETCH.
  - JUMP(9): PCWrite=1, PCSource=10, InstrDone=1 → FETCH.
- Unlisted encodings (10–15, or 12–15 when the optional feature is enabled) → FETCH on the next edge, with all outputs 0.
- Outputs not listed for a state are 0.
- MemRead/MemWrite remain high on every stall cycle; an access is never dropped.
- Wait states hold all outputs constant. InstrDone in MEMWR fires only on the cycle where MemReady=1.
- Latency with MemReady tied to 1:
  - lw: 5 cycles
  - sw and R-type: 4 cycles
  - beq and j: 3 cycles
  - Each stall cycle adds 1 to these counts.
- Asserting rst_n mid-instruction aborts immediately. After release, the first edge stays in FETCH.

Optional Feature:
Macro MIPS_ADDI_EN.
- Defined: opcode 001000 (addi) in DECODE → ADDI_EX(10), which drives ALUSrcA=1, ALUSrcB=10, ALUOp=00. It is followed by ADDI_WB(11), which drives RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1, then → FETCH. addi latency is 4 cycles.
- Undefined: 001000 is illegal; encodings 10 and 11 are unlisted.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - ALUSrcB and PCSource select constants
  - the state enum typedef
- One sub-module, mips_ctrl_decode: a pure combinational state-to-control-word decoder, kept separate from the next-state/register logic.

Test Plan:
- Reset: rst_n=0 mid-EXEC → all outputs 0 and State=0 immediately. Release with MemReady=1 → FETCH, then DECODE.
- lw, Op=100011, MemReady=1 → States 0,1,2,3,4. RegWrite=1 and MemtoReg=1 in cycle 5; InstrDone pulses once.
- sw with 3 stall cycles in MEMWR (MemReady low for 3 cycles) → MemWrite high for 4 consecutive cycles; InstrDone only on the last.
- beq, Op=000100: ALUOp=01 and PCWriteCond=1 in BRANCH, for both Zero=1 and Zero=0 → returns to FETCH. PCWrite=0 throughout BRANCH.
- R-type then j: ALUOp=10 in EXEC, RegDst=1 in RCOMP, then PCSource=10 and PCWrite=1 in JUMP.
- Op=001000: MIPS_ADDI_EN undefined → Illegal pulses and next state is FETCH. Defined → states 0,1,10,11 with ALUSrcB=10.
